// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between four byte-stream requesters.
// The grant is round-robin and is held for a whole packet, up to the byte tagged last.
// Bytes are paced one UART frame apart because uart_tx has no busy/ready output.
// An INIT holdoff after reset lets a frame already in flight on the line finish.
//
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   req_valid[3:0]    requester i holds a byte
//   req_last[3:0]     byte from requester i ends its packet
//   req_data[31:0]    requester i byte at [8i+7:8i]
//   req_ready[3:0]    handshake strobe (combinational), byte i taken when valid & ready
//   grant[3:0]        one-hot current owner, 0 when none
//   busy              arbiter is not in IDLE
//   pi_data[7:0]      byte to uart_tx
//   pi_flag           one-cycle start strobe to uart_tx
//   timeout_pulse     one-cycle pulse when an idle owner is dropped
//
// Optional feature: define UART_ARB_TIMEOUT_EN to release an owner whose valid stays
// low in SEND for TIMEOUT_CYC cycles. Without it SEND waits indefinitely.
module uart_tx_arbiter #(
    parameter int unsigned UART_BPS    = 9600,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned FRAME_BITS  = 10,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req_valid,
    input  logic [3:0]  req_last,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [7:0]  pi_data,
    output logic        pi_flag,
    output logic        timeout_pulse
);

    localparam int unsigned FRAME_CYC = (CLK_FREQ / UART_BPS) * FRAME_BITS;
    localparam int unsigned CNT_MAX   = (FRAME_CYC > TIMEOUT_CYC) ? FRAME_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       grant_nxt;
    logic [1:0]       last_owner, last_owner_nxt;
    logic             lastq, lastq_nxt;
    logic [7:0]       pi_data_nxt;
    logic             pi_flag_nxt;
    logic             busy_nxt;
    logic             timeout_pulse_nxt;
`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
`endif

    logic [1:0] g_idx;
    logic [1:0] pick_idx;
    logic       pick_found;

    // Handshake is only open to the owner while in SEND.
    assign req_ready = (state == ST_SEND) ? (grant & req_valid) : 4'b0000;

    // One-hot grant to index.
    always_comb begin
        g_idx = 2'd0;
        case (grant)
            4'b0010: g_idx = 2'd1;
            4'b0100: g_idx = 2'd2;
            4'b1000: g_idx = 2'd3;
            default: g_idx = 2'd0;
        endcase
    end

    // Round-robin pick: first valid requester after last_owner, wrapping back to it last.
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = 2'(last_owner + 2'(k));
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        grant_nxt         = grant;
        last_owner_nxt    = last_owner;
        lastq_nxt         = lastq;
        pi_data_nxt       = pi_data;
        pi_flag_nxt       = 1'b0;
        timeout_pulse_nxt = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        idle_cnt_nxt      = '0;
`endif
        case (state)
            ST_INIT: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt = 4'(4'b0001 << pick_idx);
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (req_valid[g_idx]) begin
                    pi_data_nxt = req_data[{g_idx, 3'b000} +: 8];
                    pi_flag_nxt = 1'b1;
                    lastq_nxt   = req_last[g_idx];
                    cnt_nxt     = CNT_W'(FRAME_CYC - 1);
                    state_nxt   = ST_WAIT;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_pulse_nxt = 1'b1;
                    grant_nxt         = 4'b0000;
                    last_owner_nxt    = g_idx;
                    state_nxt         = ST_IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
`endif
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    if (lastq) begin
                        grant_nxt      = 4'b0000;
                        last_owner_nxt = g_idx;
                        state_nxt      = ST_IDLE;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers; reset restarts the frame holdoff.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_INIT;
            cnt           <= CNT_W'(FRAME_CYC - 1);
            grant         <= 4'b0000;
            last_owner    <= 2'd3;
            lastq         <= 1'b0;
            pi_data       <= 8'h00;
            pi_flag       <= 1'b0;
            busy          <= 1'b1;
            timeout_pulse <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            grant         <= grant_nxt;
            last_owner    <= last_owner_nxt;
            lastq         <= lastq_nxt;
            pi_data       <= pi_data_nxt;
            pi_flag       <= pi_flag_nxt;
            busy          <= busy_nxt;
            timeout_pulse <= timeout_pulse_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt      <= idle_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized packet traffic.
// Expected bytes (owner, data) come from a packet-level round-robin model and are
// popped by an independent monitor whenever pi_flag is seen.
module tb_uart_tx_arbiter;

    localparam int unsigned FRAME = 100;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic        timeout_pulse;

    uart_tx_arbiter #(
        .UART_BPS   (100),
        .CLK_FREQ   (1000),
        .FRAME_BITS (10),
        .TIMEOUT_CYC(50)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .pi_data      (pi_data),
        .pi_flag      (pi_flag),
        .timeout_pulse(timeout_pulse)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_t;

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    byte_t rq[4][$];
    exp_t  sbq[$];
    int    flag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    last_flag = -100000;
    int    mlast    = 3;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop on each byte strobe, plus pacing and handshake legality.
    always @(negedge sys_clk) begin
        if (pi_flag) begin
            exp_t e;
            check("pi_flag_spacing", 32'(cyc - last_flag >= 101), 32'd1);
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte actual=%0h expected=none (cycle %0d)", pi_data, cyc);
            end else begin
                e = sbq.pop_front();
                check("pi_data", 32'(pi_data), 32'(e.data));
                check("grant_at_flag", 32'(grant), 32'(4'(4'b0001 << e.owner)));
            end
            last_flag = cyc;
            flag_q.push_back(cyc);
        end
        if (req_ready != 4'b0000)
            check("ready_legal",
                  32'({((req_ready & ~(grant & req_valid)) == 4'b0000), $onehot(req_ready)}), 32'd3);
`ifndef UART_ARB_TIMEOUT_EN
        if (timeout_pulse) check("timeout_pulse_off", 32'(timeout_pulse), 32'd0);
`endif
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_hs(input int i, input int bound);
        bit ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge sys_clk);
            if (req_valid[i] && req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("handshake_req%0d", i), 32'(ok), 32'd1);
        tick();
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge sys_clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_idle", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        sys_rst   = 1'b1;
        tick();
        tick();
        sys_rst   = 1'b0;
        mlast     = 3;
    endtask

    // Reference: packets leave in round-robin order, each packet whole.
    task automatic model_push();
        int idx[4] = '{default: 0};
        forever begin
            int  c = 0;
            bit  found = 1'b0;
            byte_t b;
            for (int k = 1; k <= 4; k++) begin
                c = (mlast + k) % 4;
                if (idx[c] < rq[c].size()) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            do begin
                b = rq[c][idx[c]];
                idx[c]++;
                sbq.push_back({2'(c), b.data});
            end while (!b.last);
            mlast = c;
        end
    endtask

    task automatic drive(input int pos[4], input int gap[4]);
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < rq[i].size()) begin
                req_data[8*i +: 8] = rq[i][pos[i]].data;
                req_last[i]        = rq[i][pos[i]].last;
                req_valid[i]       = (gap[i] == 0);
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // Requesters present their packet queues; owner may pause mid-packet up to gap_max cycles.
    task automatic run_traffic(input int gap_max, input int bound);
        int   pos[4] = '{default: 0};
        int   gap[4] = '{default: 0};
        logic [3:0] hs;
        bit   done = 1'b0;
        model_push();
        drive(pos, gap);
        for (int n = 0; n < bound; n++) begin
            @(negedge sys_clk);
            hs = req_valid & req_ready;
            done = !busy && (hs == 4'b0000);
            for (int i = 0; i < 4; i++) if (pos[i] < rq[i].size()) done = 1'b0;
            if (done) break;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    gap[i] = rq[i][pos[i]].last ? 0 : int'($urandom_range(gap_max, 0));
                    pos[i]++;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
            end
            drive(pos, gap);
        end
        check("traffic_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) rq[i].delete();
    endtask

    initial begin
        int n;
        int bad;
        int rst_cyc;
        bit ok;
        sys_rst   = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h0;

        // 1: reset values and INIT holdoff length
        tick(); tick(); tick();
        @(negedge sys_clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_pi", 32'({pi_flag, pi_data, timeout_pulse, req_ready}), 32'd0);
        tick();
        sys_rst = 1'b0;
        n = 0;
        bad = 0;
        forever begin
            @(negedge sys_clk);
            if (!busy || n > 300) break;
            if (pi_flag || req_ready != 4'b0000) bad++;
            n++;
        end
        check("init_busy_cycles", 32'(n), 32'(FRAME));
        check("init_quiet", 32'(bad), 32'd0);
        check("idle_outputs", 32'({grant, pi_flag, pi_data}), 32'd0);

        // 2: single byte latency
        tick();
        req_valid[0] = 1'b1; req_data[7:0] = 8'h55; req_last[0] = 1'b1;
        sbq.push_back({2'd0, 8'h55});
        @(negedge sys_clk);
        check("ready_t0", 32'(req_ready), 32'd0);
        tick();
        @(negedge sys_clk);
        check("ready_t1", 32'(req_ready), 32'b0001);
        check("grant_t1", 32'(grant), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge sys_clk);
        check("pi_flag_t2", 32'({pi_flag, pi_data}), 32'h155);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge sys_clk);
        end
        check("busy_after_flag", 32'(n), 32'(FRAME));
        mlast = 0;

        // 3: packet lock, req2 waits behind req1's three-byte packet
        tick();
        flag_q.delete();
        rq[1].push_back({1'b0, 8'hA1});
        rq[1].push_back({1'b0, 8'hA2});
        rq[1].push_back({1'b1, 8'hA3});
        rq[2].push_back({1'b1, 8'hB1});
        run_traffic(0, 2000);
        check("lock_flags", 32'(flag_q.size()), 32'd4);
        if (flag_q.size() == 4) begin
            check("lock_gap1", 32'(flag_q[1] - flag_q[0]), 32'd101);
            check("lock_gap2", 32'(flag_q[2] - flag_q[1]), 32'd101);
            check("lock_gap3", 32'(flag_q[3] - flag_q[2]), 32'd102);
        end

        // 4: round-robin from reset
        tick();
        do_reset();
        wait_idle(300);
        tick();
        rq[0].push_back({1'b1, 8'h01});
        rq[0].push_back({1'b1, 8'h02});
        rq[1].push_back({1'b1, 8'h10});
        rq[2].push_back({1'b1, 8'h20});
        rq[3].push_back({1'b1, 8'h30});
        run_traffic(0, 2000);

        // 5: owner drops valid mid-packet while req0 is pending
        tick();
        req_valid = 4'b1001;
        req_data  = {8'h3C, 16'h0, 8'hAA};
        req_last  = 4'b0001;
        sbq.push_back({2'd3, 8'h3C});
        wait_hs(3, 300);
        req_valid[3] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            if (timeout_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        check("timeout_seen", 32'(ok), 32'd1);
        check("timeout_grant", 32'(grant), 32'd0);
        tick();
        sbq.push_back({2'd0, 8'hAA});
`else
        bad = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge sys_clk);
            if (k > 2 && (grant != 4'b1000 || timeout_pulse)) bad++;
        end
        check("hold_no_timeout", 32'(bad), 32'd0);
        tick();
        sbq.push_back({2'd0, 8'hAA});
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
`endif
        wait_hs(0, 400);
        req_valid[0] = 1'b0;
        wait_idle(300);
        mlast = 0;

        // 6: reset in WAIT abandons the packet and restarts the holdoff
        tick();
        req_valid = 4'b0011;
        req_data  = {16'h0, 8'h11, 8'hB0};
        req_last  = 4'b0001;
        sbq.push_back({2'd1, 8'h11});
        wait_hs(1, 300);
        req_data[15:8] = 8'h12;
        repeat (30) tick();
        sys_rst = 1'b1;
        tick();
        rst_cyc = cyc;
        sys_rst = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'({busy, pi_flag}), 32'b10);
        sbq.push_back({2'd0, 8'hB0});
        mlast = 3;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (pi_flag) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check("mid_rst_served", 32'(ok), 32'd1);
        check("mid_rst_delay", 32'(cyc - rst_cyc), 32'd102);
        tick();
        req_valid[0] = 1'b0;
        wait_idle(300);
        mlast = 0;

        // Randomized packet traffic
        for (int r = 0; r < 4; r++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                int npk = int'($urandom_range(2, 0));
                for (int p = 0; p < npk; p++) begin
                    int len = int'($urandom_range(3, 1));
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            run_traffic(3, 20000);
        end

        repeat (5) tick();
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
